// File: rtl/psram_qspi_model.sv
// Behavioural QSPI/QPI PSRAM: EBh quad read, 38h quad write, 24-bit address.
// Define PSRAM_QPI_EN to enable 35h/F5h QPI mode entry/exit.
`timescale 1ns/1ps
module psram_qspi_model #(
   parameter int DEPTH       = 4194304,
   parameter int WAIT_CYCLES = 6
) (
   input  logic       sck,
   input  logic       reset,
   input  logic       ce_n,
   input  logic [3:0] dio_i,
   output logic [3:0] dio_o,
   output logic       dio_oe,
   output logic       qpi,
   output logic       err
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [2:0] {
      CMD, ADDR, WAIT, READ, WRITE, DONE, ERR
   } state_t;

   state_t        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [7:0]    cmd_q, cmd_d;
   logic [AW-1:0] addr_q, addr_d, addr_inc;
   logic [3:0]    nib_q, nib_d;
   logic          half_q, half_d;
   logic          qpi_q, qpi_d;
   logic          err_q, err_d;
   logic [3:0]    dout_q;
   logic          oe_q;
   logic          we;
   logic          cmd_last;
   logic          qpi_mode;
   logic [7:0]    mem_q [DEPTH];

`ifdef PSRAM_QPI_EN
   assign qpi_mode = qpi_q;
`else
   assign qpi_mode = 1'b0;
`endif

   assign addr_inc = addr_q + 1'b1;
   assign dio_o    = dout_q;
   assign dio_oe   = oe_q;
   assign qpi      = qpi_q;
   assign err      = err_q;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      cmd_d    = cmd_q;
      addr_d   = addr_q;
      nib_d    = nib_q;
      half_d   = half_q;
      qpi_d    = qpi_q;
      err_d    = err_q;
      we       = 1'b0;
      cmd_last = 1'b0;
      unique case (state_q)
         CMD: begin
            cnt_d = cnt_q + 4'd1;
            if (qpi_mode) begin
               cmd_d    = {cmd_q[3:0], dio_i};
               cmd_last = (cnt_q == 4'd1);
            end else begin
               cmd_d    = {cmd_q[6:0], dio_i[0]};
               cmd_last = (cnt_q == 4'd7);
            end
            if (cmd_last) begin
               cnt_d = '0;
               case (cmd_d)
                  8'hEB, 8'h38: state_d = ADDR;
`ifdef PSRAM_QPI_EN
                  8'h35: begin
                     qpi_d   = 1'b1;
                     state_d = DONE;
                  end
                  8'hF5: begin
                     if (qpi_mode) begin
                        qpi_d   = 1'b0;
                        state_d = DONE;
                     end else begin
                        err_d   = 1'b1;
                        state_d = ERR;
                     end
                  end
`endif
                  default: begin
                     err_d   = 1'b1;
                     state_d = ERR;
                  end
               endcase
            end
         end
         ADDR: begin
            // Bits above the array size fall off: address is taken mod DEPTH
            addr_d = AW'({addr_q, dio_i});
            cnt_d  = cnt_q + 4'd1;
            if (cnt_q == 4'd5) begin
               cnt_d   = '0;
               half_d  = 1'b0;
               state_d = (cmd_q == 8'hEB) ? WAIT : WRITE;
            end
         end
         WAIT: begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'(WAIT_CYCLES - 1)) begin
               cnt_d   = '0;
               state_d = READ;
            end
         end
         READ: begin
            half_d = ~half_q;
            if (half_q) addr_d = addr_inc;
         end
         WRITE: begin
            if (!half_q) begin
               nib_d  = dio_i;
               half_d = 1'b1;
            end else begin
               we     = 1'b1;
               addr_d = addr_inc;
               half_d = 1'b0;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge sck or posedge reset or posedge ce_n) begin
      if (reset || ce_n) begin
         state_q <= CMD;
         cnt_q   <= '0;
         cmd_q   <= '0;
         addr_q  <= '0;
         nib_q   <= '0;
         half_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cmd_q   <= cmd_d;
         addr_q  <= addr_d;
         nib_q   <= nib_d;
         half_q  <= half_d;
      end
   end

   // Mode and error flags survive ce_n; only reset clears them
   always_ff @(posedge sck or posedge reset) begin
      if (reset) begin
         qpi_q <= 1'b0;
         err_q <= 1'b0;
      end else if (!ce_n) begin
         qpi_q <= qpi_d;
         err_q <= err_d;
      end
   end

   always_ff @(posedge sck) begin
      if (we && !ce_n && !reset) mem_q[addr_q] <= {nib_q, dio_i};
   end

   always_ff @(negedge sck or posedge reset or posedge ce_n) begin
      if (reset || ce_n) begin
         dout_q <= '0;
         oe_q   <= 1'b0;
      end else if (state_q == READ) begin
         oe_q   <= 1'b1;
         dout_q <= half_q ? mem_q[addr_q][3:0] : mem_q[addr_q][7:4];
      end else begin
         oe_q   <= 1'b0;
      end
   end

endmodule
